// File: rtl/sprite_attr_mem.sv
// sprite_attr_mem: sprite x/y/img/en table with request port (re/we/action/addr/data -> data/rd_valid/busy) and registered scan port (scan_idx -> scan_attr)
module sprite_attr_mem #(
  parameter int NUM_SPRITES = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        sprite_action,
  input  logic [ADDR_W-1:0] sprite_addr,
  input  logic [7:0]        sprite_write_data,
  input  logic              sprite_re,
  input  logic              sprite_we,
  output logic [31:0]       sprite_data,
  output logic              sprite_rd_valid,
  output logic              sprite_busy,
  input  logic [ADDR_W-1:0] scan_idx,
  output logic [24:0]       scan_attr
);
  typedef enum logic [1:0] {CLEAR, IDLE, RMW} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SPRITES - 1);
  state_t state;
  logic [ADDR_W-1:0] cnt, rmw_addr, wa;
  logic rmw_y;
  logic [7:0] rmw_op;
  logic [7:0] x_mem [NUM_SPRITES];
  logic [7:0] y_mem [NUM_SPRITES];
  logic [7:0] img_mem [NUM_SPRITES];
  logic en_mem [NUM_SPRITES];
  logic idle, clr, rmw, rd_ok, wr_ok, wx, wy, wi, wen, e_d;
  logic [7:0] x_d, y_d, i_d;
  logic [31:0] rd_d;
  always_comb begin
    idle = state == IDLE;
    clr = state == CLEAR;
    rmw = state == RMW;
    rd_ok = idle && sprite_re && !sprite_we && (sprite_action < 4'd4);
    wr_ok = idle && sprite_we && !sprite_re && (sprite_action inside {[4'd4:4'd10]});
    wa = clr ? cnt : rmw ? rmw_addr : sprite_addr;
    wx = clr || (rmw && !rmw_y) || (wr_ok && sprite_action == 4'd4);
    wy = clr || (rmw && rmw_y) || (wr_ok && sprite_action == 4'd5);
    wi = clr || (wr_ok && sprite_action == 4'd6);
    wen = clr || (wr_ok && sprite_action == 4'd7);
    x_d = clr ? 8'h00 : rmw ? x_mem[rmw_addr] + rmw_op : sprite_write_data;
    y_d = clr ? 8'h00 : rmw ? y_mem[rmw_addr] + rmw_op : sprite_write_data;
    i_d = clr ? 8'h00 : sprite_write_data;
    e_d = !clr && sprite_write_data[0];
    rd_d = sprite_action[1:0] == 2'd0 ? {24'h0, x_mem[sprite_addr]} :
           sprite_action[1:0] == 2'd1 ? {24'h0, y_mem[sprite_addr]} :
           sprite_action[1:0] == 2'd2 ? {24'h0, img_mem[sprite_addr]} :
                                        {31'h0, en_mem[sprite_addr]};
  end
  always_ff @(posedge clk) begin
    if (wx) x_mem[wa] <= x_d;
    if (wy) y_mem[wa] <= y_d;
    if (wi) img_mem[wa] <= i_d;
    if (wen) en_mem[wa] <= e_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      sprite_busy <= 1'b1;
      sprite_data <= '0;
      sprite_rd_valid <= 1'b0;
      scan_attr <= '0;
      rmw_addr <= '0;
      rmw_y <= 1'b0;
      rmw_op <= '0;
    end else begin
      sprite_rd_valid <= rd_ok;
      if (rd_ok) sprite_data <= rd_d;
      scan_attr <= {en_mem[scan_idx], img_mem[scan_idx], y_mem[scan_idx], x_mem[scan_idx]};
      if (clr) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= IDLE;
          sprite_busy <= 1'b0;
        end
      end else if (rmw) begin
        state <= IDLE;
        sprite_busy <= 1'b0;
      end else if (wr_ok && sprite_action == 4'd10) begin
        state <= CLEAR;
        cnt <= '0;
        sprite_busy <= 1'b1;
      end else if (wr_ok && (sprite_action inside {4'd8, 4'd9})) begin
        state <= RMW;
        sprite_busy <= 1'b1;
        rmw_addr <= sprite_addr;
        rmw_y <= sprite_action[0];
        rmw_op <= sprite_write_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_attr_mem.sv
// tb_sprite_attr_mem: directed stimulus with queued expected reads checked by an rd_valid monitor
module tb_sprite_attr_mem;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] act = '0;
  logic [7:0] addr = '0, wdata = '0, scan_idx = '0;
  logic re = 1'b0, we = 1'b0;
  logic [31:0] data;
  logic rd_valid, busy;
  logic [24:0] scan_attr;
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  sprite_attr_mem dut (
    .clk(clk), .rst_n(rst_n), .sprite_action(act), .sprite_addr(addr),
    .sprite_write_data(wdata), .sprite_re(re), .sprite_we(we),
    .sprite_data(data), .sprite_rd_valid(rd_valid), .sprite_busy(busy),
    .scan_idx(scan_idx), .scan_attr(scan_attr)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] a, input logic [7:0] ad, input logic [7:0] d, input logic r, input logic w);
    @(negedge clk);
    act = a; addr = ad; wdata = d; re = r; we = w;
  endtask
  task automatic rd(input logic [3:0] a, input logic [7:0] ad, input logic [31:0] e);
    issue(a, ad, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      re = 1'b0; we = 1'b0;
    end
  endtask
  task automatic wait_sweep();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_len", n, 256);
  endtask
  task automatic scan_zero();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      scan_idx = 8'(i);
      @(negedge clk);
      check("scan_zero", 32'(scan_attr), 32'h0);
    end
  endtask
  task automatic check_reset();
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_scan", 32'(scan_attr), 32'h0);
  endtask
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", data);
      end else check("rd_data", data, exp_q.pop_front());
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    wait_sweep();
    scan_zero();
    issue(4'd4, 8'd5, 8'h3C, 1'b0, 1'b1);
    rd(4'd0, 8'd5, 32'h3C);
    idle(2);
    issue(4'd5, 8'd7, 8'hFE, 1'b0, 1'b1);
    issue(4'd9, 8'd7, 8'h05, 1'b0, 1'b1);
    idle(1);
    check("add_busy", 32'(busy), 32'h1);
    idle(1);
    check("add_busy_end", 32'(busy), 32'h0);
    rd(4'd1, 8'd7, 32'h03);
    issue(4'd9, 8'd7, 8'hFF, 1'b0, 1'b1);
    idle(2);
    rd(4'd1, 8'd7, 32'h02);
    idle(2);
    issue(4'd7, 8'd9, 8'h01, 1'b0, 1'b1);
    issue(4'd6, 8'd9, 8'hA5, 1'b0, 1'b1);
    idle(1);
    scan_idx = 8'd9;
    @(negedge clk);
    check("scan_9", 32'(scan_attr), 32'h1A50000);
    issue(4'd4, 8'd9, 8'h11, 1'b0, 1'b1);
    idle(1);
    check("scan_same_edge", 32'(scan_attr), 32'h1A50000);
    @(negedge clk);
    check("scan_after", 32'(scan_attr), 32'h1A50011);
    rd(4'd3, 8'd9, 32'h1);
    rd(4'd2, 8'd9, 32'hA5);
    idle(2);
    issue(4'd8, 8'd5, 8'h01, 1'b0, 1'b1);
    issue(4'd0, 8'd5, 8'h00, 1'b1, 1'b0);
    idle(2);
    rd(4'd0, 8'd5, 32'h3D);
    issue(4'd4, 8'd5, 8'h77, 1'b1, 1'b1);
    issue(4'd4, 8'd5, 8'h55, 1'b1, 1'b0);
    issue(4'd0, 8'd5, 8'h66, 1'b0, 1'b1);
    issue(4'd10, 8'd0, 8'h00, 1'b1, 1'b1);
    idle(1);
    check("illegal_no_busy", 32'(busy), 32'h0);
    rd(4'd0, 8'd5, 32'h3D);
    idle(2);
    issue(4'd4, 8'd200, 8'hC8, 1'b0, 1'b1);
    issue(4'd4, 8'd255, 8'hAB, 1'b0, 1'b1);
    issue(4'd7, 8'd255, 8'h01, 1'b0, 1'b1);
    rd(4'd0, 8'd255, 32'hAB);
    issue(4'd10, 8'd0, 8'h00, 1'b0, 1'b1);
    idle(1);
    repeat (99) @(negedge clk);
    check("clear_busy_100", 32'(busy), 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    wait_sweep();
    rd(4'd0, 8'd200, 32'h0);
    rd(4'd0, 8'd255, 32'h0);
    rd(4'd3, 8'd255, 32'h0);
    rd(4'd1, 8'd7, 32'h0);
    rd(4'd2, 8'd9, 32'h0);
    rd(4'd3, 8'd9, 32'h0);
    idle(3);
    scan_zero();
    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
